// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the 16-bit SPI register-access link: frame geometry,
// controller state encoding, peripheral register map and a frame builder.
// No ports (package).
// -----------------------------------------------------------------------------
package spi_pkg;

   localparam int FRAME_W = 16;
   localparam int ADDR_W  = 7;
   localparam int DATA_W  = 8;
   localparam int RW_BIT  = 15;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SHIFT,
      ST_HOLD,
      ST_GAP
   } spi_state_e;

   // Peripheral register map
   localparam logic [ADDR_W-1:0] ADDR_EN_REG_OUT_7_0   = 7'h00;
   localparam logic [ADDR_W-1:0] ADDR_EN_REG_OUT_15_8  = 7'h01;
   localparam logic [ADDR_W-1:0] ADDR_EN_REG_PWM_7_0   = 7'h02;
   localparam logic [ADDR_W-1:0] ADDR_EN_REG_PWM_15_8  = 7'h03;
   localparam logic [ADDR_W-1:0] ADDR_PWM_DUTY_CYCLE   = 7'h04;

   // Reads carry a zero data byte so the peripheral never sees stale write data.
   function automatic logic [FRAME_W-1:0] build_frame(
      input logic              wr,
      input logic [ADDR_W-1:0] addr,
      input logic [DATA_W-1:0] wdata
   );
      return {wr, addr, (wr ? wdata : {DATA_W{1'b0}})};
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a single asynchronous bit, reset to 0.
// Ports:
//   clk   - destination clock
//   rst_n - asynchronous active-low reset
//   d     - asynchronous input
//   q     - synchronized output (two clk cycles of latency)
// -----------------------------------------------------------------------------
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_p0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_p0 <= 1'b0;
         q       <= 1'b0;
      end else begin
         meta_p0 <= d;
         q       <= meta_p0;
      end
   end

endmodule

// File: rtl/spi_controller.sv
// -----------------------------------------------------------------------------
// spi_controller
// Mode-0 SPI initiator for 16-bit register-access frames
// ({R/W, addr[6:0], data[7:0]}, MSB first). One command per handshake.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   - command handshake (ready only when idle)
//   cmd_write             - 1 = write, 0 = read
//   cmd_addr, cmd_wdata   - register address / write data
//   rsp_valid, rsp_rdata  - one-cycle frame-end pulse, read data (0 for writes)
//   busy                  - high from handshake until ready returns
//   ncs, sclk, copi       - serial outputs, all registered
//   cipo                  - serial input, synchronized internally
// -----------------------------------------------------------------------------
module spi_controller
   import spi_pkg::*;
#(
   parameter int CLK_DIV  = 4,
   parameter int CS_SETUP = 2,
   parameter int CS_HOLD  = 2,
   parameter int CS_IDLE  = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              busy,
   output logic              ncs,
   output logic              sclk,
   output logic              copi,
   input  logic              cipo
);

   localparam logic [15:0] HALF_LAST  = 16'(CLK_DIV - 1);
   localparam logic [15:0] PER_LAST   = 16'(2 * CLK_DIV - 1);
   localparam logic [15:0] SETUP_LAST = 16'(CS_SETUP - 1);
   localparam logic [15:0] HOLD_LAST  = 16'(CS_HOLD - 1);
   localparam logic [15:0] IDLE_LAST  = 16'(CS_IDLE - 1);

   spi_state_e         state;
   logic [15:0]        cnt;
   logic [3:0]         bit_cnt;
   logic [FRAME_W-1:0] tx_sr;
   logic [DATA_W-1:0]  rx_sr;
   logic               is_write;
   logic               cipo_s;
   logic [FRAME_W-1:0] cmd_frame;

   assign cmd_frame = build_frame(cmd_write, cmd_addr, cmd_wdata);

   sync_2ff u_cipo_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (cipo),
      .q     (cipo_s)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         bit_cnt   <= '0;
         tx_sr     <= '0;
         rx_sr     <= '0;
         is_write  <= 1'b0;
         ncs       <= 1'b1;
         sclk      <= 1'b0;
         copi      <= 1'b0;
         cmd_ready <= 1'b1;
         busy      <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               // cmd_ready is high in this state, so cmd_valid alone is a handshake.
               if (cmd_valid) begin
                  tx_sr     <= cmd_frame;
                  is_write  <= cmd_write;
                  rx_sr     <= '0;
                  copi      <= cmd_frame[RW_BIT];
                  ncs       <= 1'b0;
                  cmd_ready <= 1'b0;
                  busy      <= 1'b1;
                  cnt       <= '0;
                  state     <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               if (cnt == SETUP_LAST) begin
                  cnt     <= '0;
                  bit_cnt <= 4'd15;
                  sclk    <= 1'b1;
                  state   <= ST_SHIFT;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            ST_SHIFT: begin
               // cnt runs over one full bit period; high half comes first.
               cnt <= cnt + 16'd1;
               if (cnt == HALF_LAST) begin
                  sclk <= 1'b0;
                  // Last cycle of the high half: synchronizer output is settled.
                  if (bit_cnt < 4'd8) begin
                     rx_sr <= {rx_sr[DATA_W-2:0], cipo_s};
                  end
                  // Bit 0 stays on copi through the final low half.
                  if (bit_cnt != 4'd0) begin
                     tx_sr <= {tx_sr[FRAME_W-2:0], 1'b0};
                     copi  <= tx_sr[FRAME_W-2];
                  end
               end
               if (cnt == PER_LAST) begin
                  cnt <= '0;
                  if (bit_cnt == 4'd0) begin
                     state <= ST_HOLD;
                  end else begin
                     bit_cnt <= bit_cnt - 4'd1;
                     sclk    <= 1'b1;
                  end
               end
            end
            ST_HOLD: begin
               if (cnt == HOLD_LAST) begin
                  cnt       <= '0;
                  ncs       <= 1'b1;
                  copi      <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_rdata <= is_write ? '0 : rx_sr;
                  state     <= ST_GAP;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            ST_GAP: begin
               if (cnt == IDLE_LAST) begin
                  cnt       <= '0;
                  cmd_ready <= 1'b1;
                  busy      <= 1'b0;
                  state     <= ST_IDLE;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_controller.sv
// -----------------------------------------------------------------------------
// tb_spi_controller
// Directed bench for spi_controller. Three instances share the clock, reset
// and command fields: u_dut0 with default timing, u_dut1 with CLK_DIV=3 and
// u_dut2 with CLK_DIV=9 (both CS_SETUP=1, CS_HOLD=5). Expected waveforms are
// derived from the edge-time formulas relative to the handshake cycle.
// -----------------------------------------------------------------------------
module tb_spi_controller;

   logic       clk;
   logic       rst_n;
   logic       cmd_write;
   logic [6:0] cmd_addr;
   logic [7:0] cmd_wdata;

   logic       cmd_valid [3];
   logic       cipo      [3];
   logic       cmd_ready [3];
   logic       rsp_valid [3];
   logic [7:0] rsp_rdata [3];
   logic       busy      [3];
   logic       ncs       [3];
   logic       sclk      [3];
   logic       copi      [3];

   int p_cd [3] = '{4, 3, 9};
   int p_cs [3] = '{2, 1, 1};
   int p_ch [3] = '{2, 5, 5};
   int p_ci [3] = '{2, 2, 2};

   int total = 0;
   int bad   = 0;

   spi_controller u_dut0 (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
      .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .busy(busy[0]),
      .ncs(ncs[0]), .sclk(sclk[0]), .copi(copi[0]), .cipo(cipo[0])
   );

   spi_controller #(.CLK_DIV(3), .CS_SETUP(1), .CS_HOLD(5), .CS_IDLE(2)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
      .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .busy(busy[1]),
      .ncs(ncs[1]), .sclk(sclk[1]), .copi(copi[1]), .cipo(cipo[1])
   );

   spi_controller #(.CLK_DIV(9), .CS_SETUP(1), .CS_HOLD(5), .CS_IDLE(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid[2]), .cmd_ready(cmd_ready[2]),
      .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid[2]), .rsp_rdata(rsp_rdata[2]), .busy(busy[2]),
      .ncs(ncs[2]), .sclk(sclk[2]), .copi(copi[2]), .cipo(cipo[2])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #600000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   // Runs one frame on instance d, acting as the peripheral on cipo, and
   // measures it against the formula waveform. Called just after a posedge
   // (+1) with the instance idle; returns in the same phase at the cycle
   // cmd_ready is expected back.
   task automatic run_frame(
      input  int         d,
      input  logic       wr,
      input  logic [6:0] a,
      input  logic [7:0] wd,
      input  logic [7:0] rb,
      input  bit         hold,
      input  int         pulse_at,
      output int         e_ncs,
      output int         e_sclk,
      output int         e_rsp,
      output int         e_rdy,
      output logic [15:0] word,
      output logic [7:0]  rd_e,
      output logic [7:0]  rd_end
   );
      int cd, s, e, r, j;
      bit exp_sclk;
      cd = p_cd[d];
      s  = 1 + p_cs[d];
      e  = s + 32 * cd + p_ch[d];
      r  = e + p_ci[d];
      e_ncs = 0; e_sclk = 0; e_rsp = 0; e_rdy = 0;
      word = '0; rd_e = '0;
      cmd_write = wr; cmd_addr = a; cmd_wdata = wd;
      cmd_valid[d] = 1'b1;
      cipo[d] = 1'b0;
      @(posedge clk); #1;
      if (!hold) cmd_valid[d] = 1'b0;
      for (int c = 1; c <= r; c++) begin
         if (c > 1) begin
            @(posedge clk); #1;
         end
         exp_sclk = (c >= s) && (c < s + 32 * cd) && (((c - s) / cd) % 2 == 0);
         if (ncs[d] !== (c >= e)) e_ncs++;
         if (c >= e && copi[d] !== 1'b0) e_ncs++;
         if (sclk[d] !== exp_sclk) e_sclk++;
         if (rsp_valid[d] !== (c == e)) e_rsp++;
         if (cmd_ready[d] !== (c >= r) || busy[d] !== (c < r)) e_rdy++;
         if (c >= s && c < s + 32 * cd && (c - s) % (2 * cd) == 0)
            word = {word[14:0], copi[d]};
         if (c == e) rd_e = rsp_rdata[d];
         // Peripheral launches data bits 7..0 on the falls of bits 8..1.
         if (c >= s && c < s + 32 * cd && (c - s) % (2 * cd) == cd) begin
            j = (c - s) / (2 * cd);
            if (j >= 7 && j <= 14) cipo[d] = rb[14 - j];
         end
         if (c == e) cipo[d] = 1'b0;
         if (pulse_at != 0 && c == pulse_at) cmd_valid[d] = 1'b1;
         if (pulse_at != 0 && c == pulse_at + 1) cmd_valid[d] = 1'b0;
      end
      rd_end = rsp_rdata[d];
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      for (int i = 0; i < 3; i++) begin
         cmd_valid[i] = 1'b0;
         cipo[i] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      total++;
      if ({ncs[0], sclk[0], copi[0], cmd_ready[0], busy[0], rsp_valid[0]} !== 6'b100100) begin
         bad++;
         $display("FAIL reset_ctrl0: got ncs,sclk,copi,rdy,busy,rsp=%b%b%b%b%b%b want 100100",
                  ncs[0], sclk[0], copi[0], cmd_ready[0], busy[0], rsp_valid[0]);
      end
      total++;
      if (rsp_rdata[0] !== 8'h00) begin
         bad++;
         $display("FAIL reset_rdata0: got %h want 00", rsp_rdata[0]);
      end
      total++;
      if ({ncs[1], ncs[2], cmd_ready[1], cmd_ready[2]} !== 4'b1111) begin
         bad++;
         $display("FAIL reset_others: got ncs1,ncs2,rdy1,rdy2=%b%b%b%b want 1111",
                  ncs[1], ncs[2], cmd_ready[1], cmd_ready[2]);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_read();
      int en, es, er, ey;
      logic [15:0] w;
      logic [7:0] r0, r1;
      run_frame(0, 1'b0, 7'h02, 8'hEE, 8'h3C, 1'b0, 0, en, es, er, ey, w, r0, r1);
      total++;
      if (w !== 16'h0200) begin bad++; $display("FAIL read_frame: got %h want 0200", w); end
      total++;
      if (r0 !== 8'h3C) begin bad++; $display("FAIL read_rdata: got %h want 3c", r0); end
      total++;
      if (r1 !== 8'h3C) begin bad++; $display("FAIL read_rdata_hold: got %h want 3c", r1); end
      total++;
      if (en + es + er + ey !== 0) begin
         bad++;
         $display("FAIL read_timing: err ncs=%0d sclk=%0d rsp=%0d rdy=%0d want all 0", en, es, er, ey);
      end
   endtask

   task automatic test_write();
      int en, es, er, ey;
      logic [15:0] w;
      logic [7:0] r0, r1;
      run_frame(0, 1'b1, 7'h04, 8'hA5, 8'hFF, 1'b0, 0, en, es, er, ey, w, r0, r1);
      total++;
      if (w !== 16'h84A5) begin bad++; $display("FAIL write_frame: got %h want 84a5", w); end
      total++;
      if (r0 !== 8'h00) begin bad++; $display("FAIL write_rdata: got %h want 00", r0); end
      total++;
      if (en !== 0 || es !== 0) begin
         bad++;
         $display("FAIL write_ncs_sclk: err ncs=%0d sclk=%0d want 0 0", en, es);
      end
      total++;
      if (er !== 0 || ey !== 0) begin
         bad++;
         $display("FAIL write_rsp_ready: err rsp=%0d rdy=%0d want 0 0", er, ey);
      end
   endtask

   task automatic test_back_to_back();
      int en, es, er, ey, errs, extra;
      logic [15:0] w [3];
      logic [7:0] r0, r1;
      errs = 0;
      run_frame(0, 1'b1, 7'h00, 8'h11, 8'h00, 1'b1, 0, en, es, er, ey, w[0], r0, r1);
      errs += en + es + er + ey;
      run_frame(0, 1'b1, 7'h01, 8'h22, 8'h00, 1'b1, 0, en, es, er, ey, w[1], r0, r1);
      errs += en + es + er + ey;
      run_frame(0, 1'b0, 7'h03, 8'h33, 8'h5A, 1'b0, 0, en, es, er, ey, w[2], r0, r1);
      errs += en + es + er + ey;
      total++;
      if (errs !== 0) begin bad++; $display("FAIL b2b_timing: errors=%0d want 0", errs); end
      total++;
      if ({w[0], w[1], w[2]} !== {16'h8011, 16'h8122, 16'h0300}) begin
         bad++;
         $display("FAIL b2b_frames: got %h %h %h want 8011 8122 0300", w[0], w[1], w[2]);
      end
      total++;
      if (r0 !== 8'h5A) begin bad++; $display("FAIL b2b_rdata: got %h want 5a", r0); end
      extra = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (ncs[0] !== 1'b1) extra++;
      end
      total++;
      if (extra !== 0) begin bad++; $display("FAIL b2b_no_extra: ncs low cycles=%0d want 0", extra); end
   endtask

   task automatic test_ignored();
      int en, es, er, ey, extra;
      logic [15:0] w;
      logic [7:0] r0, r1;
      run_frame(0, 1'b0, 7'h00, 8'h00, 8'h96, 1'b0, 50, en, es, er, ey, w, r0, r1);
      total++;
      if (w !== 16'h0000 || r0 !== 8'h96) begin
         bad++;
         $display("FAIL ignored_frame: got frame %h rdata %h want 0000 96", w, r0);
      end
      total++;
      if (en + es + er + ey !== 0) begin
         bad++;
         $display("FAIL ignored_timing: err ncs=%0d sclk=%0d rsp=%0d rdy=%0d want all 0", en, es, er, ey);
      end
      extra = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (ncs[0] !== 1'b1 || rsp_valid[0] !== 1'b0) extra++;
      end
      total++;
      if (extra !== 0) begin bad++; $display("FAIL ignored_no_extra: active cycles=%0d want 0", extra); end
   endtask

   task automatic test_reset_mid();
      int rises, n, quiet, en, es, er, ey;
      bit prev;
      logic [15:0] w;
      logic [7:0] r0, r1;
      cmd_write = 1'b1; cmd_addr = 7'h04; cmd_wdata = 8'h11;
      cmd_valid[0] = 1'b1;
      @(posedge clk); #1;
      cmd_valid[0] = 1'b0;
      prev = sclk[0];
      rises = 0; n = 0;
      while (rises < 7 && n < 300) begin
         @(posedge clk); #1;
         n++;
         if (sclk[0] && !prev) rises++;
         prev = sclk[0];
      end
      total++;
      if (rises !== 7 || sclk[0] !== 1'b1 || ncs[0] !== 1'b0) begin
         bad++;
         $display("FAIL rstmid_reach: rises=%0d sclk=%b ncs=%b want 7 1 0", rises, sclk[0], ncs[0]);
      end
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if ({ncs[0], sclk[0], copi[0], cmd_ready[0], busy[0]} !== 5'b10010) begin
         bad++;
         $display("FAIL rstmid_async: got ncs,sclk,copi,rdy,busy=%b%b%b%b%b want 10010",
                  ncs[0], sclk[0], copi[0], cmd_ready[0], busy[0]);
      end
      total++;
      if (rsp_rdata[0] !== 8'h00) begin bad++; $display("FAIL rstmid_rdata: got %h want 00", rsp_rdata[0]); end
      #2;
      rst_n = 1'b1;
      quiet = 0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (ncs[0] !== 1'b1 || sclk[0] !== 1'b0 || rsp_valid[0] !== 1'b0) quiet++;
      end
      total++;
      if (quiet !== 0) begin bad++; $display("FAIL rstmid_no_resume: active cycles=%0d want 0", quiet); end
      run_frame(0, 1'b1, 7'h01, 8'hFF, 8'h00, 1'b0, 0, en, es, er, ey, w, r0, r1);
      total++;
      if (w !== 16'h81FF || r0 !== 8'h00) begin
         bad++;
         $display("FAIL rstmid_after: got frame %h rdata %h want 81ff 00", w, r0);
      end
      total++;
      if (en + es + er + ey !== 0) begin
         bad++;
         $display("FAIL rstmid_after_timing: err ncs=%0d sclk=%0d rsp=%0d rdy=%0d want all 0", en, es, er, ey);
      end
   endtask

   task automatic test_sweep();
      int en, es, er, ey;
      logic [15:0] w;
      logic [7:0] r0, r1;
      // CLK_DIV=3 read: tightest synchronizer margin
      run_frame(1, 1'b0, 7'h7F, 8'h33, 8'hC5, 1'b0, 0, en, es, er, ey, w, r0, r1);
      total++;
      if (en + es + er + ey !== 0) begin
         bad++;
         $display("FAIL div3_timing: err ncs=%0d sclk=%0d rsp=%0d rdy=%0d want all 0", en, es, er, ey);
      end
      total++;
      if (w !== 16'h7F00 || r0 !== 8'hC5) begin
         bad++;
         $display("FAIL div3_data: got frame %h rdata %h want 7f00 c5", w, r0);
      end
      // CLK_DIV=9 write
      run_frame(2, 1'b1, 7'h03, 8'h5A, 8'h00, 1'b0, 0, en, es, er, ey, w, r0, r1);
      total++;
      if (en + es + er + ey !== 0) begin
         bad++;
         $display("FAIL div9_wr_timing: err ncs=%0d sclk=%0d rsp=%0d rdy=%0d want all 0", en, es, er, ey);
      end
      total++;
      if (w !== 16'h835A || r0 !== 8'h00) begin
         bad++;
         $display("FAIL div9_wr_data: got frame %h rdata %h want 835a 00", w, r0);
      end
      // CLK_DIV=9 read
      run_frame(2, 1'b0, 7'h01, 8'h00, 8'h81, 1'b0, 0, en, es, er, ey, w, r0, r1);
      total++;
      if (w !== 16'h0100 || r0 !== 8'h81 || en + es + er + ey !== 0) begin
         bad++;
         $display("FAIL div9_rd: got frame %h rdata %h errs %0d want 0100 81 0",
                  w, r0, en + es + er + ey);
      end
   endtask

   initial begin
      test_reset();
      test_read();
      test_write();
      test_back_to_back();
      test_ignored();
      test_reset_mid();
      test_sweep();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
